// File: rtl/uart_pkt_ctrl.sv
// uart_pkt_ctrl: parses SYNC/CMD/LEN/payload/CHK packets from the UART byte
// receiver, buffers the payload and holds each verified packet for the host
// until it is acknowledged. Bad length, bad checksum, framing errors and
// inter-byte timeouts abort the packet with a one-cycle error pulse.
module uart_pkt_ctrl #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 4096,
  localparam int        AW          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  input  logic          rx_ferr,
  output logic          pkt_valid,
  output logic [7:0]    pkt_cmd,
  output logic [7:0]    pkt_len,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  input  logic          pkt_ack,
  output logic          err_len,
  output logic          err_chk,
  output logic          err_frame,
  output logic          err_timeout,
  output logic [7:0]    drop_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    LEN,
    DATA,
    CHK,
    HOLD
  } state_t;

  state_t        state;
  logic [7:0]    cur_cmd;
  logic [7:0]    cur_len;
  logic [7:0]    chk;
  logic [7:0]    idx;
  logic [TW-1:0] to_cnt;
  logic [7:0]    buffer [MAX_LEN];
  logic          buf_we;

  // A payload byte lands in the buffer only when it is clean and we are in DATA.
  assign buf_we  = rx_valid && !rx_ferr && (state == DATA) && !reset;
  assign rd_data = buffer[rd_addr];

  // Payload storage carries no reset so it can map onto plain memory.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buffer[idx[AW-1:0]] <= rx_data;
    end
  end

  // Packet parser, timeout supervision, hold/ack handshake and drop counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cur_cmd     <= '0;
      cur_len     <= '0;
      chk         <= '0;
      idx         <= '0;
      to_cnt      <= '0;
      pkt_valid   <= 1'b0;
      pkt_cmd     <= '0;
      pkt_len     <= '0;
      err_len     <= 1'b0;
      err_chk     <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      err_len     <= 1'b0;
      err_chk     <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid && !rx_ferr && (rx_data == SYNC_BYTE)) begin
            state  <= CMD;
            to_cnt <= '0;
          end
        end
        CMD, LEN, DATA, CHK: begin
          if (rx_valid) begin
            to_cnt <= '0;
            if (rx_ferr) begin
              err_frame <= 1'b1;
              state     <= IDLE;
            end else begin
              case (state)
                CMD: begin
                  cur_cmd <= rx_data;
                  chk     <= rx_data;
                  state   <= LEN;
                end
                LEN: begin
                  chk     <= chk ^ rx_data;
                  cur_len <= rx_data;
                  idx     <= '0;
                  if (rx_data > 8'(MAX_LEN)) begin
                    err_len <= 1'b1;
                    state   <= IDLE;
                  end else if (rx_data == 8'd0) begin
                    state <= CHK;
                  end else begin
                    state <= DATA;
                  end
                end
                DATA: begin
                  chk <= chk ^ rx_data;
                  idx <= idx + 8'd1;
                  if (idx == cur_len - 8'd1) begin
                    state <= CHK;
                  end
                end
                CHK: begin
                  if (rx_data == chk) begin
                    state     <= HOLD;
                    pkt_valid <= 1'b1;
                    pkt_cmd   <= cur_cmd;
                    pkt_len   <= cur_len;
                  end else begin
                    err_chk <= 1'b1;
                    state   <= IDLE;
                  end
                end
                default: begin
                  state <= IDLE;
                end
              endcase
            end
          end else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        HOLD: begin
          if (rx_valid && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
          end
          if (pkt_ack) begin
            state     <= IDLE;
            pkt_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_pkt_ctrl.sv
// tb_uart_pkt_ctrl: directed packets drive the controller; every expected
// packet or error pulse is queued when issued and a negedge monitor pops and
// compares whenever the DUT raises pkt_valid or an err_* pulse.
`timescale 1ns/10ps
module tb_uart_pkt_ctrl;

  localparam int MAX_LEN     = 16;
  localparam int TIMEOUT_CYC = 4096;
  localparam int AW          = 4;

  typedef enum logic [2:0] {EV_PKT, EV_LEN, EV_CHK, EV_FRAME, EV_TO} ev_t;

  typedef struct packed {
    ev_t                       kind;
    logic [7:0]                cmd;
    logic [7:0]                len;
    logic [MAX_LEN-1:0][7:0]   data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ferr;
  logic          pkt_valid;
  logic [7:0]    pkt_cmd;
  logic [7:0]    pkt_len;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic          pkt_ack;
  logic          err_len;
  logic          err_chk;
  logic          err_frame;
  logic          err_timeout;
  logic [7:0]    drop_cnt;

  exp_t exp_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;
  logic prev_valid   = 1'b0;

  uart_pkt_ctrl #(
    .SYNC_BYTE  (8'hA5),
    .MAX_LEN    (MAX_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ferr    (rx_ferr),
    .pkt_valid  (pkt_valid),
    .pkt_cmd    (pkt_cmd),
    .pkt_len    (pkt_len),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .pkt_ack    (pkt_ack),
    .err_len    (err_len),
    .err_chk    (err_chk),
    .err_frame  (err_frame),
    .err_timeout(err_timeout),
    .drop_cnt   (drop_cnt)
  );

  // 100 MHz system clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic pushEvent(input ev_t kind, input logic [7:0] cmd, input logic [7:0] len,
                           input logic [MAX_LEN-1:0][7:0] data);
    exp_t e;
    e.kind = kind;
    e.cmd  = cmd;
    e.len  = len;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic pushError(input ev_t kind);
    pushEvent(kind, 8'h00, 8'h00, '0);
  endtask

  // One byte strobe, sampled by the DUT on the next rising edge.
  task automatic applyStimulus(input logic [7:0] b, input logic ferr);
    rx_valid = 1'b1;
    rx_data  = b;
    rx_ferr  = ferr;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full frame: SYNC, CMD, LEN, LEN payload bytes, CHK.
  task automatic sendFrame(input logic [7:0] cmd, input logic [7:0] len,
                           input logic [MAX_LEN-1:0][7:0] data, input logic [7:0] chk);
    applyStimulus(8'hA5, 1'b0);
    applyStimulus(cmd, 1'b0);
    applyStimulus(len, 1'b0);
    for (int i = 0; i < int'(len); i++) applyStimulus(data[i], 1'b0);
    applyStimulus(chk, 1'b0);
  endtask

  // Release the held packet, optionally with a byte strobed in the same cycle.
  task automatic ackPacket(input logic with_byte, input logic [7:0] b);
    checkOutput("pkt_valid_before_ack", {7'd0, pkt_valid}, 8'd1);
    pkt_ack  = 1'b1;
    rx_valid = with_byte;
    rx_data  = b;
    @(posedge clk);
    #1;
    pkt_ack  = 1'b0;
    rx_valid = 1'b0;
    checkOutput("pkt_valid_after_ack", {7'd0, pkt_valid}, 8'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_pkt_valid"}, {7'd0, pkt_valid}, 8'd0);
    checkOutput({tag, "_pkt_cmd"}, pkt_cmd, 8'd0);
    checkOutput({tag, "_pkt_len"}, pkt_len, 8'd0);
    checkOutput({tag, "_errs"}, {4'd0, err_len, err_chk, err_frame, err_timeout}, 8'd0);
    checkOutput({tag, "_drop_cnt"}, drop_cnt, 8'd0);
  endtask

  task automatic handleEvent(input ev_t kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL unexpected_event: got kind %0d, expected none", kind);
    end else begin
      e = exp_q.pop_front();
      checkOutput("event_kind", 8'(kind), 8'(e.kind));
      if (kind == EV_PKT && e.kind == EV_PKT) begin
        checkOutput("pkt_cmd", pkt_cmd, e.cmd);
        checkOutput("pkt_len", pkt_len, e.len);
        for (int i = 0; i < int'(e.len); i++) begin
          rd_addr = AW'(i);
          #0.1;
          checkOutput("rd_data", rd_data, e.data[i]);
        end
      end
    end
  endtask

  // Monitor: any new hold or error pulse consumes the next expected event.
  always @(negedge clk) begin
    if (pkt_valid === 1'b1 && prev_valid !== 1'b1) handleEvent(EV_PKT);
    if (err_len === 1'b1)     handleEvent(EV_LEN);
    if (err_chk === 1'b1)     handleEvent(EV_CHK);
    if (err_frame === 1'b1)   handleEvent(EV_FRAME);
    if (err_timeout === 1'b1) handleEvent(EV_TO);
    prev_valid = pkt_valid;
  end

  // Directed stimulus sequence.
  initial begin
    logic [MAX_LEN-1:0][7:0] d;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rx_ferr  = 1'b0;
    pkt_ack  = 1'b0;
    idle(3);
    checkAllZero("reset");
    reset = 1'b0;
    idle(1);

    $display("[TB] idle junk and framed SYNC are ignored");
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'hFF, 1'b0);
    applyStimulus(8'h13, 1'b0);
    applyStimulus(8'hA5, 1'b1);

    $display("[TB] three-byte packet");
    d = '0; d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    pushEvent(EV_PKT, 8'h10, 8'd3, d);
    sendFrame(8'h10, 8'd3, d, 8'h13);
    idle(1);
    ackPacket(1'b1, 8'hA5);
    checkOutput("drop_on_ack_cycle", drop_cnt, 8'd1);
    checkOutput("cmd_held_after_ack", pkt_cmd, 8'h10);
    checkOutput("len_held_after_ack", pkt_len, 8'd3);

    $display("[TB] zero-length packet and bad checksum");
    pushEvent(EV_PKT, 8'h20, 8'd0, '0);
    sendFrame(8'h20, 8'd0, '0, 8'h20);
    idle(1);
    ackPacket(1'b0, 8'h00);
    pushError(EV_CHK);
    sendFrame(8'h20, 8'd0, '0, 8'h21);
    idle(2);
    checkOutput("no_pkt_after_bad_chk", {7'd0, pkt_valid}, 8'd0);

    $display("[TB] oversize length then normal packet");
    pushError(EV_LEN);
    applyStimulus(8'hA5, 1'b0);
    applyStimulus(8'h05, 1'b0);
    applyStimulus(8'h11, 1'b0);
    d = '0; d[0] = 8'hAA;
    pushEvent(EV_PKT, 8'h07, 8'd1, d);
    sendFrame(8'h07, 8'd1, d, 8'hAC);
    idle(1);
    ackPacket(1'b0, 8'h00);

    $display("[TB] inter-byte timeout");
    pushError(EV_TO);
    applyStimulus(8'hA5, 1'b0);
    applyStimulus(8'h10, 1'b0);
    idle(TIMEOUT_CYC - 1);
    checkOutput("timeout_not_early", {7'd0, err_timeout}, 8'd0);
    idle(1);
    checkOutput("timeout_pulse", {7'd0, err_timeout}, 8'd1);
    idle(1);
    checkOutput("timeout_one_cycle", {7'd0, err_timeout}, 8'd0);

    $display("[TB] byte exactly at expiry wins");
    applyStimulus(8'hA5, 1'b0);
    applyStimulus(8'h10, 1'b0);
    idle(TIMEOUT_CYC - 1);
    pushEvent(EV_PKT, 8'h10, 8'd0, '0);
    applyStimulus(8'h00, 1'b0);
    checkOutput("no_timeout_at_expiry", {7'd0, err_timeout}, 8'd0);
    applyStimulus(8'h10, 1'b0);
    idle(1);
    ackPacket(1'b0, 8'h00);

    $display("[TB] drops while holding saturate");
    d = '0; d[0] = 8'h44;
    pushEvent(EV_PKT, 8'h33, 8'd1, d);
    sendFrame(8'h33, 8'd1, d, 8'h76);
    applyStimulus(8'h5A, 1'b1);
    for (int i = 1; i < 253; i++) applyStimulus(8'(i), 1'b0);
    checkOutput("drop_cnt_254", drop_cnt, 8'd254);
    for (int i = 0; i < 47; i++) applyStimulus(8'hA5, 1'b0);
    checkOutput("drop_cnt_sat", drop_cnt, 8'd255);
    ackPacket(1'b1, 8'h77);
    checkOutput("drop_cnt_sat_ack", drop_cnt, 8'd255);
    d = '0; d[0] = 8'h01; d[1] = 8'h02;
    pushEvent(EV_PKT, 8'h55, 8'd2, d);
    sendFrame(8'h55, 8'd2, d, 8'h54);
    idle(1);
    ackPacket(1'b0, 8'h00);

    $display("[TB] framing error in payload");
    pushError(EV_FRAME);
    applyStimulus(8'hA5, 1'b0);
    applyStimulus(8'h40, 1'b0);
    applyStimulus(8'h04, 1'b0);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h02, 1'b1);
    idle(2);

    $display("[TB] reset mid-payload");
    applyStimulus(8'hA5, 1'b0);
    applyStimulus(8'h40, 1'b0);
    applyStimulus(8'h04, 1'b0);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h02, 1'b0);
    reset = 1'b1;
    idle(1);
    checkAllZero("mid_reset");
    reset = 1'b0;
    pushEvent(EV_PKT, 8'h66, 8'd0, '0);
    sendFrame(8'h66, 8'd0, '0, 8'h66);
    idle(1);
    ackPacket(1'b0, 8'h00);

    idle(20);
    checkOutput("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
